// File: rtl/hex_display_ctrl_if.sv
// Bus bundle for hex_display_ctrl: load/data inputs, status and display outputs.
interface hex_display_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic                  blank_lz;
  logic                  enable;
  logic                  pending;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic [8*DIGITS-1:0]   seg_static;

  modport master (
    output load, data, dp, blank_lz, enable,
    input  pending, seg, an, seg_static
  );

  modport slave (
    input  load, data, dp, blank_lz, enable,
    output pending, seg, an, seg_static
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Hex display controller: 1..8 digits, static or scanned seven-segment drive,
// frame-synchronous value transfer, decimal points and leading-zero blanking.
module hex_display_ctrl #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int MODE       = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  hex_display_ctrl_if.slave bus
);

  localparam int   TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic AL = (ACTIVE_LOW != 0);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Pending (captured) and shown (displayed) register sets.
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, show_data_q, show_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, show_dp_q, show_dp_d;
  logic                pend_blz_q, pend_blz_d, show_blz_q, show_blz_d;
  logic                pend_flag_q, pend_flag_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [8*DIGITS-1:0] seg_static_q, seg_static_d;

  logic                tick_wrap, frame_wrap, xfer;
  logic [DIGITS-1:0][7:0] enc_all;
  logic [DIGITS-1:0]   an_hot;

  assign tick_wrap  = (tick_q == TW'(SCAN_DIV - 1));
  assign frame_wrap = tick_wrap && (digit_q == DW'(DIGITS - 1));
  // Static mode transfers as soon as something is pending; scan mode waits for the frame edge
  // so a digit never shows a mix of old and new values within one frame.
  assign xfer       = (MODE == 0) ? pend_flag_q : (pend_flag_q && frame_wrap);
  assign an_hot     = DIGITS'(1) << digit_q;

  // Per-digit active-high encoding including dp and leading-zero blanking.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic       upper_nz;
      assign nib = show_data_q[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        // Digit 0 is never blanked so a zero value still reads "0".
        assign upper_nz = 1'b1;
      end else begin : g_upper
        assign upper_nz = |show_data_q[4*DIGITS-1:4*gi];
      end
      assign enc_all[gi] = {show_dp_q[gi], (show_blz_q && !upper_nz) ? 7'h00 : hex7(nib)};
    end
  endgenerate

  // Next state for the pending/shown sets and scan counters.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_blz_d  = pend_blz_q;
    pend_flag_d = pend_flag_q;
    show_data_d = show_data_q;
    show_dp_d   = show_dp_q;
    show_blz_d  = show_blz_q;
    // Transfer moves the pre-edge pending contents; a coincident load refills pending.
    if (xfer) begin
      show_data_d = pend_data_q;
      show_dp_d   = pend_dp_q;
      show_blz_d  = pend_blz_q;
      pend_flag_d = 1'b0;
    end
    if (bus.load) begin
      pend_data_d = bus.data;
      pend_dp_d   = bus.dp;
      pend_blz_d  = bus.blank_lz;
      pend_flag_d = 1'b1;
    end
    tick_d  = tick_wrap ? '0 : tick_q + 1'b1;
    digit_d = digit_q;
    if (tick_wrap) begin
      digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  // Output drive levels; disabled or unused outputs sit at their inactive level.
  always_comb begin
    seg_d        = {8{AL}};
    an_d         = {DIGITS{AL}};
    seg_static_d = {(8*DIGITS){AL}};
    if (bus.enable) begin
      if (MODE != 0) begin
        seg_d = enc_all[digit_q] ^ {8{AL}};
        an_d  = an_hot ^ {DIGITS{AL}};
      end else begin
        seg_static_d = enc_all ^ {(8*DIGITS){AL}};
      end
    end
  end

  // State and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blz_q   <= 1'b0;
      pend_flag_q  <= 1'b0;
      show_data_q  <= '0;
      show_dp_q    <= '0;
      show_blz_q   <= 1'b0;
      tick_q       <= '0;
      digit_q      <= '0;
      seg_q        <= {8{AL}};
      an_q         <= {DIGITS{AL}};
      seg_static_q <= {(8*DIGITS){AL}};
    end else begin
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blz_q   <= pend_blz_d;
      pend_flag_q  <= pend_flag_d;
      show_data_q  <= show_data_d;
      show_dp_q    <= show_dp_d;
      show_blz_q   <= show_blz_d;
      tick_q       <= tick_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      seg_static_q <= seg_static_d;
    end
  end

  assign bus.pending    = pend_flag_q;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.seg_static = seg_static_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench: scan instance (4 digits, SCAN_DIV=4, active-low) and
// static instance (active-high) share clock and reset.
module tb_hex_display_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  hex_display_ctrl_if #(.DIGITS(4)) bus_a ();
  hex_display_ctrl_if #(.DIGITS(4)) bus_b ();

  hex_display_ctrl #(.DIGITS(4), .SCAN_DIV(4), .MODE(1), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  hex_display_ctrl #(.DIGITS(4), .SCAN_DIV(4), .MODE(0), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at cycle %0d: observed %h required %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  task automatic advance_to(input int target);
    while (cyc < target) next();
  endtask

  // Step n cycles checking the scan bus; tbl byte d is the expected seg for digit d.
  task automatic span(input int n, input logic [31:0] tbl, input string tag);
    logic [15:0] an_tbl;
    int d;
    an_tbl = 16'h7BDE;
    for (int k = 0; k < n; k++) begin
      next();
      d = ((cyc - 1) / 4) % 4;
      chk({tag, " seg"}, 32'(bus_a.seg), 32'(tbl[8*d +: 8]));
      chk({tag, " an"}, 32'(bus_a.an), 32'(an_tbl[4*d +: 4]));
      $display("cycle %0d %s: seg=%h an=%h", cyc, tag, bus_a.seg, bus_a.an);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1;
    bus_a.load = 1'b0; bus_a.data = '0; bus_a.dp = '0; bus_a.blank_lz = 1'b0; bus_a.enable = 1'b1;
    bus_b.load = 1'b0; bus_b.data = '0; bus_b.dp = '0; bus_b.blank_lz = 1'b0; bus_b.enable = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // First edge after reset: value 0, digit 0 lit; static shows "0000".
    next();
    chk("first seg", 32'(bus_a.seg), 32'hC0);
    chk("first an", 32'(bus_a.an), 32'hE);
    chk("first pending", 32'(bus_a.pending), 32'h0);
    chk("static first", bus_b.seg_static, 32'h3F3F3F3F);
    chk("static seg idle", 32'(bus_b.seg), 32'h0);
    chk("static an idle", 32'(bus_b.an), 32'h0);
    advance_to(7);

    // Reset asserted mid-cycle drives inactive levels immediately.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async rst seg", 32'(bus_a.seg), 32'hFF);
    chk("async rst an", 32'(bus_a.an), 32'hF);
    chk("async rst static", bus_b.seg_static, 32'h0);
    $display("async reset: seg=%h an=%h seg_static=%h", bus_a.seg, bus_a.an, bus_b.seg_static);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // Rotation after reset: an E,D,B,7, every digit "0".
    span(16, 32'hC0C0C0C0, "rot");

    // Frame-synchronous load at tick 1 of digit 1.
    advance_to(21);
    bus_a.data = 16'h12AF; bus_a.dp = 4'b0001; bus_a.blank_lz = 1'b0; bus_a.load = 1'b1;
    next();
    bus_a.load = 1'b0;
    while (cyc < 32) begin
      chk("pend wait", 32'(bus_a.pending), 32'h1);
      chk("old shown", 32'(bus_a.seg), 32'hC0);
      next();
    end
    chk("pend cleared", 32'(bus_a.pending), 32'h0);
    chk("old at wrap", 32'(bus_a.seg), 32'hC0);
    span(16, 32'hF9A4880E, "12AF");

    // Leading-zero blanking.
    bus_a.data = 16'h0030; bus_a.dp = 4'b0000; bus_a.blank_lz = 1'b1; bus_a.load = 1'b1;
    next();
    bus_a.load = 1'b0;
    advance_to(64);
    chk("blz pend cleared", 32'(bus_a.pending), 32'h0);
    span(16, 32'hFFFFB0C0, "blz 0030");
    bus_a.data = 16'h0000; bus_a.blank_lz = 1'b1; bus_a.load = 1'b1;
    next();
    bus_a.load = 1'b0;
    advance_to(96);
    span(16, 32'hFFFFFFC0, "blz 0000");

    // Load A mid-frame, then B exactly on the frame-wrap cycle.
    advance_to(115);
    bus_a.data = 16'h4567; bus_a.dp = 4'b0000; bus_a.blank_lz = 1'b0; bus_a.load = 1'b1;
    next();
    bus_a.load = 1'b0;
    advance_to(127);
    chk("pend A", 32'(bus_a.pending), 32'h1);
    bus_a.data = 16'hBCDE; bus_a.dp = 4'b1000; bus_a.load = 1'b1;
    next();
    bus_a.load = 1'b0;
    chk("pend across wrap", 32'(bus_a.pending), 32'h1);
    span(16, 32'h999282F8, "frame A");
    chk("pend B done", 32'(bus_a.pending), 32'h0);
    span(16, 32'h03C6A186, "frame B");

    // Enable gating mid-frame, then resume without phase reset.
    advance_to(166);
    bus_a.enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next();
      chk("disabled seg", 32'(bus_a.seg), 32'hFF);
      chk("disabled an", 32'(bus_a.an), 32'hF);
    end
    bus_a.enable = 1'b1;
    span(6, 32'h03C6A186, "resume");

    // Static mode: one-cycle pending, new segments on the third edge.
    advance_to(180);
    bus_b.data = 16'h8000; bus_b.dp = 4'b0000; bus_b.blank_lz = 1'b0; bus_b.load = 1'b1;
    next();
    bus_b.load = 1'b0;
    chk("static pend set", 32'(bus_b.pending), 32'h1);
    next();
    chk("static pend clr", 32'(bus_b.pending), 32'h0);
    chk("static old", bus_b.seg_static, 32'h3F3F3F3F);
    next();
    chk("static new", bus_b.seg_static, 32'h7F3F3F3F);
    chk("static seg held", 32'(bus_b.seg), 32'h0);
    chk("static an held", 32'(bus_b.an), 32'h0);
    $display("static load: seg_static=%h", bus_b.seg_static);
    bus_b.enable = 1'b0;
    next();
    chk("static disabled", bus_b.seg_static, 32'h0);
    bus_b.enable = 1'b1;
    next();
    chk("static reenabled", bus_b.seg_static, 32'h7F3F3F3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
